// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: ASCII constants,
// parser state encoding and hex-digit-count derivation.
package uart_cmd_parser_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_W  = 8'h57;
   localparam logic [7:0] ASCII_R  = 8'h52;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_3  = 8'h33;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_F  = 8'h46;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_REG,
      ST_W_HEX,
      ST_R_REG,
      ST_R_TERM,
      ST_R_ISSUE,
      ST_ERR
   } state_e;

   // Maximum number of hex digits a write command may carry.
   function automatic int nib_of(input int data_w);
      return data_w / 4;
   endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bus bundle between the command parser and its surroundings: RX byte
// stream, register-write port, register-read port and print path.
interface uart_cmd_parser_if #(
   parameter int DATA_W = 16
);
   logic [7:0]        i_rx_data;
   logic              i_rx_valid;
   logic              o_wr_stb;
   logic [1:0]        o_wr_reg;
   logic [DATA_W-1:0] o_wr_data;
   logic [1:0]        o_rd_reg;
   logic [DATA_W-1:0] i_rd_data;
   logic              o_tx_stb;
   logic [1:0]        o_tx_reg;
   logic [DATA_W-1:0] o_tx_data;
   logic              i_tx_busy;
   logic              o_err_stb;
   logic              o_busy;

   // Parser side.
   modport master (
      input  i_rx_data, i_rx_valid, i_rd_data, i_tx_busy,
      output o_wr_stb, o_wr_reg, o_wr_data, o_rd_reg,
             o_tx_stb, o_tx_reg, o_tx_data, o_err_stb, o_busy
   );

   // UART / register file / print path side.
   modport slave (
      output i_rx_data, i_rx_valid, i_rd_data, i_tx_busy,
      input  o_wr_stb, o_wr_reg, o_wr_data, o_rd_reg,
             o_tx_stb, o_tx_reg, o_tx_data, o_err_stb, o_busy
   );
endinterface

// File: rtl/uart_cmd_parser_chardec.sv
// Combinational classifier for one received byte.
// Optional macro UART_CMD_LOWERCASE_EN: fold 'a'-'z' to uppercase so that
// 'w', 'r' and 'a'-'f' decode like their uppercase forms.
module uart_cmd_parser_chardec
   import uart_cmd_parser_pkg::*;
(
   input  logic [7:0] ch_in,
   output logic       is_hex,
   output logic [3:0] nib,
   output logic       is_reg,
   output logic [1:0] reg_idx,
   output logic       is_w,
   output logic       is_r,
   output logic       is_term
);
   logic [7:0] ch;

   // Classify the byte; letters are optionally case-folded first.
   always_comb begin
      ch = ch_in;
`ifdef UART_CMD_LOWERCASE_EN
      if (ch_in >= 8'h61 && ch_in <= 8'h7A) ch = ch_in & 8'hDF;
`endif
      is_w    = (ch == ASCII_W);
      is_r    = (ch == ASCII_R);
      is_term = (ch_in == ASCII_CR) || (ch_in == ASCII_LF);
      is_reg  = (ch_in >= ASCII_0) && (ch_in <= ASCII_3);
      reg_idx = ch_in[1:0];
      is_hex  = 1'b0;
      nib     = 4'd0;
      if (ch >= ASCII_0 && ch <= ASCII_9) begin
         is_hex = 1'b1;
         nib    = ch[3:0];
      end else if (ch >= ASCII_A && ch <= ASCII_F) begin
         is_hex = 1'b1;
         nib    = ch[3:0] + 4'd9;
      end
   end
endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "W<r><hex..>" + CR/LF writes a register,
// "R<r>" + CR/LF prints a register through the UART print path.
// Optional macro UART_CMD_LOWERCASE_EN (decoded in the chardec sub-module).
module uart_cmd_parser
   import uart_cmd_parser_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input logic                clk,
   input logic                rst,
   uart_cmd_parser_if.master  bus
);
   localparam int NIB   = nib_of(DATA_W);
   localparam int CNT_W = $clog2(NIB + 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic              wr_stb_q, wr_stb_d;
   logic [1:0]        wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [1:0]        rd_reg_q, rd_reg_d;
   logic              tx_stb_q, tx_stb_d;
   logic [1:0]        tx_reg_q, tx_reg_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              err_stb_q, err_stb_d;

   logic       is_hex, is_reg, is_w, is_r, is_term;
   logic [3:0] nib;
   logic [1:0] reg_idx;

   uart_cmd_parser_chardec u_chardec (
      .ch_in   (bus.i_rx_data),
      .is_hex  (is_hex),
      .nib     (nib),
      .is_reg  (is_reg),
      .reg_idx (reg_idx),
      .is_w    (is_w),
      .is_r    (is_r),
      .is_term (is_term)
   );

   // Next-state and next-output logic for one accepted byte per cycle.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wr_stb_d  = 1'b0;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      rd_reg_d  = rd_reg_q;
      tx_stb_d  = 1'b0;
      tx_reg_d  = tx_reg_q;
      tx_data_d = tx_data_q;
      err_stb_d = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.i_rx_valid) begin
            if (is_w)              state_d = ST_W_REG;
            else if (is_r)         state_d = ST_R_REG;
            else if (!is_term) begin
               state_d   = ST_ERR;
               err_stb_d = 1'b1;
            end
         end
         ST_W_REG: if (bus.i_rx_valid) begin
            if (is_reg) begin
               idx_d   = reg_idx;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_W_HEX;
            end else begin
               state_d   = ST_ERR;
               err_stb_d = 1'b1;
            end
         end
         ST_W_HEX: if (bus.i_rx_valid) begin
            if (is_hex && cnt_q < CNT_W'(NIB)) begin
               // Accumulator starts at zero, so short numbers come out zero-extended.
               acc_d = {acc_q[DATA_W-5:0], nib};
               cnt_d = cnt_q + CNT_W'(1);
            end else if (is_term && cnt_q != '0) begin
               wr_stb_d  = 1'b1;
               wr_reg_d  = idx_q;
               wr_data_d = acc_q;
               state_d   = ST_IDLE;
            end else begin
               state_d   = ST_ERR;
               err_stb_d = 1'b1;
            end
         end
         ST_R_REG: if (bus.i_rx_valid) begin
            if (is_reg) begin
               rd_reg_d = reg_idx;
               state_d  = ST_R_TERM;
            end else begin
               state_d   = ST_ERR;
               err_stb_d = 1'b1;
            end
         end
         ST_R_TERM: if (bus.i_rx_valid) begin
            state_d = is_term ? ST_R_ISSUE : ST_ERR;
            err_stb_d = !is_term;
         end
         ST_R_ISSUE: begin
            if (!bus.i_tx_busy) begin
               tx_stb_d  = 1'b1;
               tx_reg_d  = rd_reg_q;
               tx_data_d = bus.i_rd_data;
               state_d   = ST_IDLE;
            end
            // Bytes arriving while the print request is outstanding are dropped.
            err_stb_d = bus.i_rx_valid;
         end
         ST_ERR: if (bus.i_rx_valid && is_term) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         wr_stb_q  <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         rd_reg_q  <= '0;
         tx_stb_q  <= 1'b0;
         tx_reg_q  <= '0;
         tx_data_q <= '0;
         err_stb_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         wr_stb_q  <= wr_stb_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
         rd_reg_q  <= rd_reg_d;
         tx_stb_q  <= tx_stb_d;
         tx_reg_q  <= tx_reg_d;
         tx_data_q <= tx_data_d;
         err_stb_q <= err_stb_d;
      end
   end

   assign bus.o_wr_stb  = wr_stb_q;
   assign bus.o_wr_reg  = wr_reg_q;
   assign bus.o_wr_data = wr_data_q;
   assign bus.o_rd_reg  = rd_reg_q;
   assign bus.o_tx_stb  = tx_stb_q;
   assign bus.o_tx_reg  = tx_reg_q;
   assign bus.o_tx_data = tx_data_q;
   assign bus.o_err_stb = err_stb_q;
   assign bus.o_busy    = (state_q != ST_IDLE);
endmodule
